lfsr_seq_ctrl: RTL and testbench
================================

LFSR_SEQ_CTRL -- requirements
Module: lfsr_seq_ctrl

Interface
REQ-001 SHALL have parameter OUT_W, default 8: bits per output word.
REQ-002 SHALL have parameter SEED_W, default 3: seed length, matching datapath register depth.
REQ-003 SHALL have parameter LAT, default 3: datapath seed-to-out latency, in cycles.
REQ-004 clk  in  1  sole clock; all state on posedge clk.
REQ-005 rst  in  1  synchronous, active-low reset (asserted when 0).
REQ-006 start  in  1  begin a run; sampled only in IDLE.
REQ-007 seed_val  in  SEED_W  seed, loaded MSB first.
REQ-008 run_len  in  8  words to produce; latched on accepted start.
REQ-009 lfsr_ena  out  1  drives datapath ena (1 = free-run, 0 = shift in seed).
REQ-010 lfsr_seed  out  1  drives datapath serial seed input.
REQ-011 lfsr_out  in  1  datapath serial output.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 word_valid / word_data  out  1 / OUT_W  one-entry output buffer.
REQ-014 word_ready  in  1  consumer accept; a transfer occurs when word_valid && word_ready.
REQ-015 done  out  1  one-cycle pulse at end of run.
REQ-016 overrun  out  1  sticky; set when a completed word was dropped.

Function
REQ-017 States SHALL be IDLE, LOAD, RUN, DRAIN.
REQ-018 IDLE: start=1 and run_len!=0 -> LOAD; latch seed_val and run_len; clear overrun.
REQ-019 IDLE with start=1 and run_len==0: SHALL pulse done next cycle and remain in IDLE, with no LOAD.
REQ-020 LOAD: SHALL last exactly SEED_W cycles with lfsr_ena=0 and lfsr_seed=seed bit SEED_W-1 down to 0, then go to RUN.
REQ-021 RUN: lfsr_ena=1 and lfsr_seed=0 every cycle; no stall is permitted, since ena=0 corrupts the sequence.
REQ-022 RUN: the first LAT lfsr_out samples SHALL be discarded; each later sample SHALL shift MSB-first into the packer.
REQ-023 Each time the packer holds OUT_W bits, the word is complete; the packer SHALL restart at 0 bits on the same cycle.
REQ-024 Completed word with buffer empty, or buffer transferring on the same cycle: SHALL load the buffer, so word_valid=1 next cycle.
REQ-025 Completed word with buffer full and no transfer: SHALL drop the word, set overrun, and still count the word.
REQ-026 After run_len completed words: RUN -> DRAIN, with lfsr_ena=0 and lfsr_seed=0 from then on.
REQ-027 DRAIN: SHALL go to IDLE with a done pulse on the cycle after the buffer is empty.
REQ-028 start while busy SHALL be ignored.
REQ-029 word_data SHALL hold stable while word_valid=1 and word_ready=0.
REQ-030 The word counter SHALL be 8 bits; run_len=255 SHALL complete 255 words with no wrap.

Reset
REQ-031 rst=0 at a clock edge SHALL force IDLE with packer, counters and buffer cleared.
REQ-032 rst=0 at a clock edge SHALL set busy, word_valid, word_data, done, overrun, lfsr_ena and lfsr_seed to 0.
REQ-033 Reset mid-run SHALL abandon the run with no done pulse; a later start SHALL reload the seed in full.

Structure
REQ-034 A shared package lfsr_pkg SHALL hold the state enum and default constants: OUT_W=8, SEED_W=3, LAT=3.
REQ-035 Serial-to-parallel packing SHALL be one sub-module, bit_packer (shift in, bit count, full flag).
REQ-036 The datapath itself is external and SHALL NOT be instantiated inside this block.

Verification
REQ-037 Bench SHALL include a golden model: 3-flop XOR datapath (C<=ena?C^D:seed, D<=C, out<=D).
REQ-038 seed 3'b101, run_len=2, word_ready=1 -> words 8'hB6 then 8'hDB, then done, busy=0.
REQ-039 seed 3'b000, run_len=4 -> four words 8'h00; overrun=0.
REQ-040 seed 3'b101, run_len=3, word_ready=0 throughout -> buffer holds 8'hB6; overrun=1; done only after ready asserts.
REQ-041 start with run_len=0 -> done one cycle later; lfsr_ena stays 0; busy stays 0.
REQ-042 rst=0 during RUN, then a new start with seed 3'b101, run_len=1 -> first word 8'hB6; no done from the aborted run.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared types and default constants for the LFSR sequence controller.
// The state enum, the default sizes and a small counter-width helper live here.
package lfsr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam int DEF_OUT_W  = 8;
    localparam int DEF_SEED_W = 3;
    localparam int DEF_LAT    = 3;

    // Width of a counter that must reach max_val; never narrower than 1 bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/bit_packer.sv
// Serial-to-parallel packer: shifts bits in MSB first and flags each complete W-bit word.
// The completed word is presented combinationally on the cycle its last bit arrives.
module bit_packer
    import lfsr_pkg::*;
#(
    parameter int W = DEF_OUT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         shift_en,
    input  logic         bit_in,
    output logic [W-1:0] word,
    output logic         full
);

    localparam int CW = cnt_width(W - 1);

    logic [W-2:0]  shift_q;
    logic [W-1:0]  shift_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign full = shift_en && (count_q == CW'(W - 1));
    assign word = shift_d;

    always_comb begin
        shift_d = {shift_q, bit_in};
        count_d = count_q;
        if (shift_en) begin
            count_d = full ? '0 : count_q + CW'(1);
        end
    end

    // Stale bits need no clearing after a word: the next W-1 shifts overwrite them.
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            shift_q <= '0;
            count_q <= '0;
        end else if (shift_en) begin
            shift_q <= shift_d[W-2:0];
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Sequences an external serial LFSR datapath: loads the seed, free-runs it, packs
// its output into words and hands them to a consumer through a one-entry buffer.
module lfsr_seq_ctrl
    import lfsr_pkg::*;
#(
    parameter int OUT_W  = DEF_OUT_W,
    parameter int SEED_W = DEF_SEED_W,
    parameter int LAT    = DEF_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SEED_W-1:0] seed_val,
    input  logic [7:0]        run_len,
    output logic              lfsr_ena,
    output logic              lfsr_seed,
    input  logic              lfsr_out,
    output logic              busy,
    output logic              word_valid,
    output logic [OUT_W-1:0]  word_data,
    input  logic              word_ready,
    output logic              done,
    output logic              overrun
);

    localparam int PW = cnt_width((LAT > SEED_W) ? LAT : SEED_W);

    state_t            state_q;
    logic [SEED_W-1:0] seed_q;
    logic [7:0]        len_q;
    logic [7:0]        words_q;
    logic [PW-1:0]     phase_q;
    logic              ena_q;
    logic              seed_bit_q;
    logic              busy_q;
    logic              valid_q;
    logic [OUT_W-1:0]  data_q;
    logic              done_q;
    logic              overrun_q;

    logic              accept;
    logic              pk_shift;
    logic              pk_full;
    logic [OUT_W-1:0]  pk_word;
    logic              xfer;
    logic              buf_load;

    assign accept   = (state_q == ST_IDLE) && start && (run_len != 8'd0);
    assign pk_shift = (state_q == ST_RUN) && (phase_q == PW'(LAT));
    assign xfer     = valid_q && word_ready;
    assign buf_load = pk_full && (!valid_q || word_ready);

    bit_packer #(
        .W (OUT_W)
    ) u_packer (
        .clk      (clk),
        .rst      (rst),
        .clr      (accept),
        .shift_en (pk_shift),
        .bit_in   (lfsr_out),
        .word     (pk_word),
        .full     (pk_full)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            seed_q     <= '0;
            len_q      <= '0;
            words_q    <= '0;
            phase_q    <= '0;
            ena_q      <= 1'b0;
            seed_bit_q <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (buf_load) begin
                valid_q <= 1'b1;
                data_q  <= pk_word;
            end else if (xfer) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start && (run_len == 8'd0)) begin
                        done_q <= 1'b1;
                    end else if (accept) begin
                        state_q    <= ST_LOAD;
                        busy_q     <= 1'b1;
                        seed_bit_q <= seed_val[SEED_W-1];
                        seed_q     <= seed_val << 1;
                        len_q      <= run_len;
                        words_q    <= '0;
                        phase_q    <= '0;
                        overrun_q  <= 1'b0;
                        ena_q      <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (phase_q == PW'(SEED_W - 1)) begin
                        state_q    <= ST_RUN;
                        ena_q      <= 1'b1;
                        seed_bit_q <= 1'b0;
                        phase_q    <= '0;
                    end else begin
                        phase_q    <= phase_q + PW'(1);
                        seed_bit_q <= seed_q[SEED_W-1];
                        seed_q     <= seed_q << 1;
                    end
                end
                ST_RUN: begin
                    // phase_q counts off the pipeline-fill samples before packing starts.
                    if (phase_q != PW'(LAT)) begin
                        phase_q <= phase_q + PW'(1);
                    end
                    if (pk_full) begin
                        words_q <= words_q + 8'd1;
                        if (!buf_load) begin
                            overrun_q <= 1'b1;
                        end
                        if (words_q + 8'd1 == len_q) begin
                            state_q <= ST_DRAIN;
                            ena_q   <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!valid_q) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign lfsr_ena   = ena_q;
    assign lfsr_seed  = seed_bit_q;
    assign busy       = busy_q;
    assign word_valid = valid_q;
    assign word_data  = data_q;
    assign done       = done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Bench for lfsr_seq_ctrl: a 3-flop XOR datapath closes the loop, and a timeline
// model derived from the run rules predicts every output on every cycle.
module tb_lfsr_seq_ctrl;

    localparam int OUT_W  = 8;
    localparam int SEED_W = 3;
    localparam int LAT    = 3;
    // Edge (counted from start acceptance) at which word 0's last bit is sampled.
    localparam int FIRST_DONE = SEED_W + 1 + LAT + OUT_W - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [SEED_W-1:0] seed_val = '0;
    logic [7:0]        run_len = '0;
    logic              word_ready = 1'b0;
    logic              lfsr_ena;
    logic              lfsr_seed;
    logic              lfsr_out;
    logic              busy;
    logic              word_valid;
    logic [OUT_W-1:0]  word_data;
    logic              done;
    logic              overrun;

    always #5 clk = ~clk;

    lfsr_seq_ctrl #(
        .OUT_W  (OUT_W),
        .SEED_W (SEED_W),
        .LAT    (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .seed_val   (seed_val),
        .run_len    (run_len),
        .lfsr_ena   (lfsr_ena),
        .lfsr_seed  (lfsr_seed),
        .lfsr_out   (lfsr_out),
        .busy       (busy),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_ready (word_ready),
        .done       (done),
        .overrun    (overrun)
    );

    // External datapath: C <= ena ? C^D : seed, D <= C, out <= D.
    logic dp_c = 1'b0;
    logic dp_d = 1'b0;
    logic dp_o = 1'b0;
    always_ff @(posedge clk) begin
        dp_c <= lfsr_ena ? (dp_c ^ dp_d) : lfsr_seed;
        dp_d <= dp_c;
        dp_o <= dp_d;
    end
    assign lfsr_out = dp_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    bit              m_active, m_drain, m_valid, m_done, m_over, m_busy;
    int              m_t, m_n, m_wc;
    logic [7:0]      m_data;
    logic [2:0]      m_seed;
    logic [7:0]      m_words [256];
    logic [7:0]      xq [$];

    // After an MSB-first load the MSB sits in the output flop and the LSB in C.
    task automatic build_words(input logic [2:0] s, input int n);
        bit c, d, o, nc;
        int w;
        c = s[0];
        d = s[1];
        o = s[2];
        for (int j = 0; j < n; j++) m_words[j] = 8'h00;
        for (int k = 0; k < LAT + OUT_W * n; k++) begin
            if (k >= LAT) begin
                w = (k - LAT) / OUT_W;
                m_words[w] = {m_words[w][6:0], o};
            end
            nc = c ^ d;
            o  = d;
            d  = c;
            c  = nc;
        end
    endtask

    task automatic model_step();
        bit         nv, ndone;
        logic [7:0] nd;
        if (!rst) begin
            m_active = 0; m_drain = 0; m_valid = 0; m_data = 8'h00;
            m_done = 0; m_over = 0; m_busy = 0; m_t = 0;
            return;
        end
        nv    = m_valid;
        nd    = m_data;
        ndone = 0;
        if (m_valid && word_ready) nv = 0;
        if (!m_active) begin
            if (start && run_len == 8'd0) begin
                ndone = 1;
            end else if (start) begin
                m_active = 1; m_drain = 0; m_t = 0; m_n = int'(run_len);
                m_wc = 0; m_over = 0; m_busy = 1; m_seed = seed_val;
                build_words(seed_val, int'(run_len));
            end
        end else begin
            m_t++;
            if (!m_drain) begin
                if (m_t >= FIRST_DONE && (m_t - FIRST_DONE) % OUT_W == 0) begin
                    if (!m_valid || word_ready) begin
                        nv = 1;
                        nd = m_words[m_wc];
                    end else begin
                        m_over = 1;
                    end
                    m_wc++;
                    if (m_wc == m_n) m_drain = 1;
                end
            end else if (!m_valid) begin
                m_active = 0;
                m_busy   = 0;
                ndone    = 1;
            end
        end
        m_valid = nv;
        m_data  = nd;
        m_done  = ndone;
    endtask

    task automatic tick();
        bit e_ena, e_seed;
        if (word_valid && word_ready) begin
            xq.push_back(word_data);
            $display("XFER cyc=%0d word=%02h", cyc, word_data);
        end
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        e_ena  = m_active && !m_drain && (m_t >= SEED_W);
        e_seed = (m_active && m_t < SEED_W) ? m_seed[SEED_W-1-m_t] : 1'b0;
        check("busy",      busy,       m_busy);
        check("lfsr_ena",  lfsr_ena,   e_ena);
        check("lfsr_seed", lfsr_seed,  e_seed);
        check("valid",     word_valid, m_valid);
        check("data",      word_data,  m_data);
        check("done",      done,       m_done);
        check("overrun",   overrun,    m_over);
    endtask

    task automatic run_idle(input int budget);
        int n = 0;
        while (m_active && n < budget) begin
            tick();
            n++;
        end
        check("idle_timeout", m_active, 0);
    endtask

    task automatic launch(input logic [2:0] s, input logic [7:0] len);
        $display("START cyc=%0d seed=%0b len=%0d", cyc, s, len);
        seed_val = s;
        run_len  = len;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // Two words with a always-ready consumer.
        xq.delete();
        word_ready = 1'b1;
        launch(3'b101, 8'd2);
        run_idle(400);
        check("a_count", xq.size(), 2);
        if (xq.size() == 2) begin
            check("a_word0", xq[0], 8'hB6);
            check("a_word1", xq[1], 8'hDB);
        end
        check("a_busy", busy, 0);

        // All-zero seed stays zero.
        xq.delete();
        launch(3'b000, 8'd4);
        run_idle(400);
        check("b_count", xq.size(), 4);
        foreach (xq[i]) check("b_word", xq[i], 8'h00);
        check("b_overrun", overrun, 0);

        // Consumer stalled: first word held, later words dropped.
        xq.delete();
        word_ready = 1'b0;
        launch(3'b101, 8'd3);
        repeat (60) tick();
        check("c_valid", word_valid, 1);
        check("c_data", word_data, 8'hB6);
        check("c_overrun", overrun, 1);
        check("c_no_done", done, 0);
        word_ready = 1'b1;
        run_idle(20);
        check("c_count", xq.size(), 1);

        // Zero-length run.
        launch(3'b111, 8'd0);
        check("d_done", done, 1);
        check("d_ena", lfsr_ena, 0);
        check("d_busy", busy, 0);
        tick();
        check("d_done_clr", done, 0);

        // Reset mid-run, then a fresh run reloads the seed.
        launch(3'b110, 8'd3);
        repeat (25) tick();
        check("e_busy", busy, 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        repeat (30) tick();
        xq.delete();
        launch(3'b101, 8'd1);
        run_idle(200);
        check("e_count", xq.size(), 1);
        if (xq.size() == 1) check("e_word0", xq[0], 8'hB6);

        // start held high during a run is ignored.
        xq.delete();
        seed_val = 3'b101;
        run_len  = 8'd2;
        start    = 1'b1;
        tick();
        seed_val = 3'b010;
        run_len  = 8'd9;
        run_idle(400);
        start = 1'b0;
        check("f_count", xq.size(), 2);
        if (xq.size() == 2) check("f_word1", xq[1], 8'hDB);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            word_ready = ($urandom_range(0, 9) < 6);
            start      = ($urandom_range(0, 15) == 0);
            run_len    = 8'($urandom_range(0, 7));
            seed_val   = 3'($urandom);
            rst        = ($urandom_range(0, 999) != 0);
            tick();
        end
        rst        = 1'b1;
        start      = 1'b0;
        word_ready = 1'b1;
        run_idle(400);

        // Maximum run length, no wrap.
        xq.delete();
        launch(3'($urandom_range(1, 7)), 8'd255);
        run_idle(3000);
        check("g_count", xq.size(), 255);
        check("g_overrun", overrun, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
